// File: rtl/alu_pkg.sv
// Shared op codes, status flags and FSM state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_NOT = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    FLAG_NONE      = 3'b000,
    FLAG_EQUAL     = 3'b001,
    FLAG_EXCEPTION = 3'b010,
    FLAG_OVERFLOW  = 3'b011,
    FLAG_UNDERFLOW = 3'b100,
    FLAG_ABOVE     = 3'b101
  } flag_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Signed overflow classification from operand and result sign bits.
  function automatic flag_e ovf_flag(input logic a_s, input logic b_s, input logic r_s,
                                     input logic is_sub);
    logic b_eff;
    b_eff = is_sub ? ~b_s : b_s;
    if (!a_s && !b_eff && r_s)      return FLAG_OVERFLOW;
    else if (a_s && b_eff && !r_s)  return FLAG_UNDERFLOW;
    else                            return FLAG_NONE;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the EX-stage control and the sequential ALU.
interface alu_seq_if import alu_pkg::*; #(parameter int WIDTH = 32) ();
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  flag_e            flag;

  modport master (output start, op, data_a, data_b,
                  input  busy, done, result, result_hi, flag);
  modport slave  (input  start, op, data_a, data_b,
                  output busy, done, result, result_hi, flag);
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply and restoring divide.
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             fin_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_rem;
  logic [WIDTH:0] div_try;

  always_comb begin
    acc_d    = acc_q;
    low_d    = low_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    mul_sum  = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_rem  = {acc_q, low_q[WIDTH-1]};
    div_try  = div_rem - {1'b0, opnd_q};

    if (go_i) begin
      acc_d    = '0;
      low_d    = a_i;
      opnd_d   = b_i;
      cnt_d    = CNT_W'(WIDTH);
      is_div_d = is_div_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (is_div_q) begin
        // Bit WIDTH of the trial subtraction is the borrow: set means restore.
        if (!div_try[WIDTH]) begin
          acc_d = div_try[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_rem[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = mul_sum[WIDTH:1];
        low_d = {mul_sum[0], low_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      low_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      low_q    <= low_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  // Results are the post-step values so the caller can register them on the final step.
  assign fin_o = (cnt_q == CNT_W'(1));
  assign hi_o  = acc_d;
  assign lo_o  = low_d;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops, iterative MUL/DIV.
// state   | meaning
// IDLE    | waiting for start
// RUN     | MUL/DIV iterating, busy=1
// DONE    | done=1 for one cycle; start here is accepted back-to-back
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clock,
  input  logic     reset,
  alu_seq_if.slave bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  flag_e            flag_q, flag_d;

  logic             go;
  logic             fin;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clock    (clock),
    .reset    (reset),
    .go_i     (go),
    .is_div_i (bus.op == OP_DIV),
    .a_i      (bus.data_a),
    .b_i      (bus.data_b),
    .fin_o    (fin),
    .hi_o     (iter_hi),
    .lo_o     (iter_lo)
  );

  assign sum  = bus.data_a + bus.data_b;
  assign diff = bus.data_a - bus.data_b;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flag_d      = flag_q;
    go          = 1'b0;

    if (state_q == ST_RUN) begin
      if (fin) begin
        state_d     = ST_DONE;
        result_d    = iter_lo;
        result_hi_d = iter_hi;
        flag_d      = (op_q == OP_MUL && iter_hi != '0) ? FLAG_OVERFLOW : FLAG_NONE;
      end
    end else if (bus.start) begin
      op_d        = bus.op;
      state_d     = ST_DONE;
      result_hi_d = '0;
      flag_d      = FLAG_NONE;
      case (bus.op)
        OP_ADD: begin
          result_d = sum;
          flag_d   = ovf_flag(bus.data_a[WIDTH-1], bus.data_b[WIDTH-1], sum[WIDTH-1], 1'b0);
        end
        OP_SUB: begin
          result_d = diff;
          flag_d   = ovf_flag(bus.data_a[WIDTH-1], bus.data_b[WIDTH-1], diff[WIDTH-1], 1'b1);
        end
        OP_MUL: begin
          go          = 1'b1;
          state_d     = ST_RUN;
          result_hi_d = result_hi_q;
          flag_d      = flag_q;
        end
        OP_DIV: begin
          if (bus.data_b == '0) begin
            result_d    = '1;
            result_hi_d = bus.data_a;
            flag_d      = FLAG_EXCEPTION;
          end else begin
            go          = 1'b1;
            state_d     = ST_RUN;
            result_hi_d = result_hi_q;
            flag_d      = flag_q;
          end
        end
        OP_AND: result_d = bus.data_a & bus.data_b;
        OP_OR:  result_d = bus.data_a | bus.data_b;
        OP_NOT: result_d = ~bus.data_a;
        OP_CMP: begin
          result_d = '0;
          if (bus.data_a == bus.data_b)     flag_d = FLAG_EQUAL;
          else if (bus.data_a > bus.data_b) flag_d = FLAG_ABOVE;
          else                              flag_d = FLAG_NONE;
        end
        default: begin
          result_d = '0;
          flag_d   = FLAG_EXCEPTION;
        end
      endcase
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      result_q    <= '0;
      result_hi_q <= '0;
      flag_q      <= FLAG_NONE;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flag_q      <= flag_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flag      = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: cycle-level behavioural model plus directed vectors.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Specification-level result of one operation.
  function automatic void mdl(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] r, output logic [W-1:0] h,
                              output logic [2:0] f, output bit iter);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; h = '0; f = 3'b000; iter = 0;
    case (op)
      OP_ADD: begin
        s = sa + sb; r = a + b;
        f = (s > MAXS) ? 3'b011 : (s < MINS) ? 3'b100 : 3'b000;
      end
      OP_SUB: begin
        s = sa - sb; r = a - b;
        f = (s > MAXS) ? 3'b011 : (s < MINS) ? 3'b100 : 3'b000;
      end
      OP_MUL: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0]; h = p[63:32]; iter = 1;
        f = (h != 0) ? 3'b011 : 3'b000;
      end
      OP_DIV: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; h = a; f = 3'b010; end
        else begin r = a / b; h = a % b; iter = 1; end
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOT: r = ~a;
      default: f = (a == b) ? 3'b001 : (a > b) ? 3'b101 : 3'b000;
    endcase
  endfunction

  // Model state: cycles of iteration remaining, plus the visible outputs.
  int           m_left;
  bit           m_done;
  logic [W-1:0] m_res, m_hi, p_res, p_hi;
  logic [2:0]   m_flag, p_flag;
  bit           chk_en;

  initial begin
    chk_en = 0; m_left = 0; m_done = 0;
    m_res = '0; m_hi = '0; m_flag = '0; p_res = '0; p_hi = '0; p_flag = '0;
  end

  always @(posedge clock) begin
    logic [W-1:0] r, h;
    logic [2:0]   f;
    bit           it;
    chk_en = 1;
    if (reset) begin
      m_left = 0; m_done = 0; m_res = '0; m_hi = '0; m_flag = '0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_res = p_res; m_hi = p_hi; m_flag = p_flag;
        end
      end else if (bus.start) begin
        mdl(bus.op, bus.data_a, bus.data_b, r, h, f, it);
        if (it) begin
          m_left = W; p_res = r; p_hi = h; p_flag = f;
        end else begin
          m_done = 1; m_res = r; m_hi = h; m_flag = f;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", bus.busy, m_left > 0);
      check("done", bus.done, m_done);
      check("result", bus.result, m_res);
      check("result_hi", bus.result_hi, m_hi);
      check("flag", bus.flag, m_flag);
    end
  end

  task automatic run_op(input string name, input op_e op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat, input logic [W-1:0] er,
                        input logic [W-1:0] eh, input logic [2:0] ef);
    int n;
    @(negedge clock);
    bus.start = 1; bus.op = op; bus.data_a = a; bus.data_b = b;
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      bus.start = 0;
      bus.data_a = $urandom;
      bus.data_b = $urandom;
      n++;
      if (bus.done) break;
    end
    check({name, " latency"}, n, lat);
    check({name, " result"}, bus.result, er);
    check({name, " result_hi"}, bus.result_hi, eh);
    check({name, " flag"}, bus.flag, ef);
  endtask

  initial begin
    int n;
    int seen;
    tests = 0; fails = 0;
    reset = 1; bus.start = 0; bus.op = OP_ADD; bus.data_a = '0; bus.data_b = '0;
    repeat (2) @(negedge clock);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset result", bus.result, 0);
    check("reset flag", bus.flag, 0);
    reset = 0;

    run_op("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 0, 3'b011);
    run_op("sub unf", OP_SUB, 32'h8000_0000, 32'h1, 1, 32'h7FFF_FFFF, 0, 3'b100);
    run_op("add neg", OP_ADD, 32'hFFFF_FFFE, 32'h3, 1, 32'h1, 0, 3'b000);
    run_op("mul 7x6", OP_MUL, 7, 6, 33, 42, 0, 3'b000);
    run_op("mul big", OP_MUL, 32'hFFFF_FFFF, 2, 33, 32'hFFFF_FFFE, 1, 3'b011);
    run_op("mul max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1, 32'hFFFF_FFFE, 3'b011);
    run_op("div 100/7", OP_DIV, 100, 7, 33, 14, 2, 3'b000);
    run_op("div big", OP_DIV, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF, 3'b000);
    run_op("div 5/0", OP_DIV, 5, 0, 1, 32'hFFFF_FFFF, 5, 3'b010);
    run_op("and", OP_AND, 32'hF0F0, 32'h0FF0, 1, 32'h00F0, 0, 3'b000);
    run_op("or", OP_OR, 32'hF0F0, 32'h0FF0, 1, 32'hFFF0, 0, 3'b000);
    run_op("not", OP_NOT, 32'h0, 32'h1234, 1, 32'hFFFF_FFFF, 0, 3'b000);
    run_op("cmp eq", OP_CMP, 5, 5, 1, 0, 0, 3'b001);
    run_op("cmp above", OP_CMP, 9, 3, 1, 0, 0, 3'b101);
    run_op("cmp below", OP_CMP, 3, 9, 1, 0, 0, 3'b000);

    // start pulsed mid-run with different operands must be ignored
    @(negedge clock);
    bus.start = 1; bus.op = OP_MUL; bus.data_a = 7; bus.data_b = 6;
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      n++;
      bus.start = (n == 5);
      if (n == 5) begin bus.op = OP_DIV; bus.data_a = 100; bus.data_b = 7; end
      if (bus.done) break;
    end
    check("run-ignore latency", n, 33);
    check("run-ignore result", bus.result, 42);
    check("run-ignore result_hi", bus.result_hi, 0);

    // start held through done: second op accepted with no gap
    @(negedge clock);
    bus.start = 1; bus.op = OP_MUL; bus.data_a = 3; bus.data_b = 4;
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      n++;
      if (bus.done) break;
    end
    check("b2b mul latency", n, 33);
    check("b2b mul result", bus.result, 12);
    bus.op = OP_ADD; bus.data_a = 1; bus.data_b = 2;
    @(negedge clock);
    bus.start = 0;
    check("b2b add done", bus.done, 1);
    check("b2b add result", bus.result, 3);

    // reset mid-MUL aborts with no later done
    @(negedge clock);
    bus.start = 1; bus.op = OP_MUL; bus.data_a = 7; bus.data_b = 6;
    @(negedge clock);
    bus.start = 0;
    repeat (9) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort result", bus.result, 0);
    check("abort result_hi", bus.result_hi, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) seen++;
    end
    check("abort no done", seen, 0);
    run_op("add after abort", OP_ADD, 2, 3, 1, 5, 0, 3'b000);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
